// File: rtl/rf_arb_pkg.sv
// Shared widths and round-robin index helper for the register-file port arbiter.
package rf_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  // Index that follows idx in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 < n) ? idx + 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after i_ptr (wrapping) wins.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  localparam int NP = 1 << IDX_W;

  logic [NP-1:0]    w_req_ext;
  logic [IDX_W-1:0] w_cand [N];

  assign w_req_ext = NP'(i_req);

  // Candidate k is the k-th requester visited when starting at the pointer.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign w_cand[gi] = IDX_W'((int'(i_ptr) + gi) % N);
    end
  endgenerate

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_valid && w_req_ext[w_cand[k]]) begin
        o_idx   = w_cand[k];
        o_valid = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign o_grant[gi] = o_valid && (o_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one register-file port among NUM_REQ requesters: round-robin grant,
// bounded atomic lock, r0 write protection and a one-cycle tagged read response.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ID_W         = 3,
  parameter int LOCK_MAX     = 8,
  parameter int ZERO_PROTECT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [RF_ADDR_W*NUM_REQ-1:0] req_a1,
  input  logic [RF_ADDR_W*NUM_REQ-1:0] req_a2,
  input  logic [RF_ADDR_W*NUM_REQ-1:0] req_a3,
  input  logic [RF_DATA_W*NUM_REQ-1:0] req_wd,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [RF_ADDR_W-1:0]         rf_a1,
  output logic [RF_ADDR_W-1:0]         rf_a2,
  output logic [RF_ADDR_W-1:0]         rf_a3,
  output logic [RF_DATA_W-1:0]         rf_wd3,
  output logic                         rf_we3,
  input  logic [RF_DATA_W-1:0]         rf_rd1,
  input  logic [RF_DATA_W-1:0]         rf_rd2,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic [RF_DATA_W-1:0]         rsp_rd1,
  output logic [RF_DATA_W-1:0]         rsp_rd2,
  output logic                         wr_zero_drop
);

  localparam int NP    = 1 << ID_W;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam bit ZP    = (ZERO_PROTECT != 0);

  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_owner;
  logic [ID_W-1:0]      r_rsp_id;
  logic                 r_lock_held;
  logic                 r_rsp_valid;
  logic                 r_zero_drop;
  logic [CNT_W-1:0]     r_lock_cnt;

  logic [NUM_REQ-1:0]   w_req_eff;
  logic [NUM_REQ-1:0]   w_rr_grant;
  logic [NP-1:0]        w_valid_ext;
  logic [ID_W-1:0]      w_rr_idx;
  logic [ID_W-1:0]      w_grant_idx;
  logic                 w_rr_valid;
  logic                 w_owner_valid;
  logic                 w_grant_any;
  logic [RF_ADDR_W-1:0] w_a1, w_a2, w_a3;
  logic [RF_DATA_W-1:0] w_wd;
  logic                 w_we;
  logic                 w_lock;
  logic                 w_zero_hit;
  logic                 w_retain;
  logic [CNT_W:0]       w_cnt_new;

  // Requests are masked while reset is asserted so nothing is granted during it.
  assign w_req_eff     = req_valid & {NUM_REQ{rst_n}};
  assign w_valid_ext   = NP'(w_req_eff);
  assign w_owner_valid = r_lock_held & w_valid_ext[r_owner];

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .i_req   (w_req_eff),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = w_owner_valid ? (r_owner == ID_W'(gi)) : w_rr_grant[gi];
    end
  endgenerate

  assign w_grant_any = w_owner_valid | w_rr_valid;
  assign w_grant_idx = w_owner_valid ? r_owner : w_rr_idx;

  // One-hot OR mux: all fields read as zero when nobody is granted.
  always_comb begin
    w_a1   = '0;
    w_a2   = '0;
    w_a3   = '0;
    w_wd   = '0;
    w_we   = 1'b0;
    w_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        w_a1   = req_a1[RF_ADDR_W*i +: RF_ADDR_W];
        w_a2   = req_a2[RF_ADDR_W*i +: RF_ADDR_W];
        w_a3   = req_a3[RF_ADDR_W*i +: RF_ADDR_W];
        w_wd   = req_wd[RF_DATA_W*i +: RF_DATA_W];
        w_we   = req_we[i];
        w_lock = req_lock[i];
      end
    end
  end

  assign w_zero_hit = ZP & w_we & (w_a3 == '0);
  assign rf_a1      = w_a1;
  assign rf_a2      = w_a2;
  assign rf_a3      = w_a3;
  assign rf_wd3     = w_wd;
  assign rf_we3     = w_we & ~w_zero_hit;

  // The grant that brings the count to LOCK_MAX is the owner's last one.
  assign w_cnt_new = (w_owner_valid ? {1'b0, r_lock_cnt} : '0) + (CNT_W+1)'(1);
  assign w_retain  = w_grant_any & w_lock & (w_cnt_new < (CNT_W+1)'(LOCK_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_rsp_id    <= '0;
      r_lock_held <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_zero_drop <= 1'b0;
      r_lock_cnt  <= '0;
    end else begin
      r_rsp_valid <= w_grant_any;
      r_zero_drop <= w_zero_hit;
      if (w_grant_any) r_rsp_id <= w_grant_idx;
      r_lock_held <= w_retain;
      if (w_retain) begin
        r_owner    <= w_grant_idx;
        r_lock_cnt <= w_cnt_new[CNT_W-1:0];
      end else begin
        r_lock_cnt <= '0;
        if (w_grant_any) r_rr_ptr <= ID_W'(rr_next(32'(w_grant_idx), NUM_REQ));
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_rd1      = rf_rd1;
  assign rsp_rd2      = rf_rd2;
  assign wr_zero_drop = r_zero_drop;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural arbitration/register-file model.
module tb_rf_port_arbiter;

  localparam int N    = 3;
  localparam int IDW  = 3;
  localparam int LMAX = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rf_clear = 1'b1;
  logic [N-1:0]    req_valid = '0, req_lock = '0, req_we = '0;
  logic [5*N-1:0]  req_a1 = '0, req_a2 = '0, req_a3 = '0;
  logic [32*N-1:0] req_wd = '0;
  int n_cmp  = 0;
  int n_fail = 0;

  // Instance 0: ZERO_PROTECT=1; instance 1: ZERO_PROTECT=0, same stimulus.
  logic [N-1:0]   ready0, ready1;
  logic [4:0]     a1_0, a2_0, a3_0, a1_1, a2_1, a3_1;
  logic [31:0]    wd_0, wd_1, rd1_0, rd2_0, rd1_1, rd2_1;
  logic [31:0]    rr1_0, rr2_0, rr1_1, rr2_1;
  logic           we_0, we_1, rv_0, rv_1, zd_0, zd_1;
  logic [IDW-1:0] rid_0, rid_1;
  logic [31:0]    mem0 [32];
  logic [31:0]    mem1 [32];

  always #5 clk = ~clk;

  rf_port_arbiter #(.NUM_REQ(N), .ID_W(IDW), .LOCK_MAX(LMAX), .ZERO_PROTECT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
    .req_a1(req_a1), .req_a2(req_a2), .req_a3(req_a3), .req_wd(req_wd), .req_ready(ready0),
    .rf_a1(a1_0), .rf_a2(a2_0), .rf_a3(a3_0), .rf_wd3(wd_0), .rf_we3(we_0),
    .rf_rd1(rd1_0), .rf_rd2(rd2_0), .rsp_valid(rv_0), .rsp_id(rid_0),
    .rsp_rd1(rr1_0), .rsp_rd2(rr2_0), .wr_zero_drop(zd_0)
  );

  rf_port_arbiter #(.NUM_REQ(N), .ID_W(IDW), .LOCK_MAX(LMAX), .ZERO_PROTECT(0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
    .req_a1(req_a1), .req_a2(req_a2), .req_a3(req_a3), .req_wd(req_wd), .req_ready(ready1),
    .rf_a1(a1_1), .rf_a2(a2_1), .rf_a3(a3_1), .rf_wd3(wd_1), .rf_we3(we_1),
    .rf_rd1(rd1_1), .rf_rd2(rd2_1), .rsp_valid(rv_1), .rsp_id(rid_1),
    .rsp_rd1(rr1_1), .rsp_rd2(rr2_1), .wr_zero_drop(zd_1)
  );

  // Register files with registered, read-before-write reads; not cleared by rst_n.
  always @(posedge clk) begin
    rd1_0 <= mem0[a1_0];
    rd2_0 <= mem0[a2_0];
    rd1_1 <= mem1[a1_1];
    rd2_1 <= mem1[a2_1];
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      if (we_0) mem0[a3_0] <= wd_0;
      if (we_1) mem1[a3_1] <= wd_1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0; req_lock = '0; req_we = '0;
    req_a1 = '0; req_a2 = '0; req_a3 = '0; req_wd = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic lk, input logic we,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                         input logic [31:0] wd);
    req_valid[i] = v; req_lock[i] = lk; req_we[i] = we;
    req_a1[5*i +: 5] = a1; req_a2[5*i +: 5] = a2; req_a3[5*i +: 5] = a3;
    req_wd[32*i +: 32] = wd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '1; req_we = '1; req_a3 = {5'd3, 5'd3, 5'd3}; req_wd = '1;
    @(negedge clk);
    n_cmp++; if (ready0 !== '0) begin n_fail++; $display("FAIL reset_ready: got %b expected 000", ready0); end
    n_cmp++; if (we_0 !== 1'b0) begin n_fail++; $display("FAIL reset_we3: got %b expected 0", we_0); end
    n_cmp++; if ({rv_0, rid_0, zd_0} !== '0) begin n_fail++;
      $display("FAIL reset_rsp: got valid=%b id=%0d zd=%b expected 0/0/0", rv_0, rid_0, zd_0); end
    tick();
    rf_clear = 1'b0;
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    n_cmp++; if ({a1_0, a2_0, a3_0, wd_0} !== '0) begin n_fail++;
      $display("FAIL idle_rf_bus: got a1=%0d a2=%0d a3=%0d wd=%h expected all 0", a1_0, a2_0, a3_0, wd_0); end
    $display("reset: ready=%b rsp_valid=%b", ready0, rv_0);
    tick();
  endtask

  task automatic test_write_read();
    do_reset();
    set_req(1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    n_cmp++; if (ready0 !== 3'b010 || we_0 !== 1'b1 || a3_0 !== 5'd5) begin n_fail++;
      $display("FAIL wr_grant: got ready=%b we=%b a3=%0d expected 010/1/5", ready0, we_0, a3_0); end
    tick();
    set_req(1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    n_cmp++; if (ready0 !== 3'b010 || rv_0 !== 1'b1 || rid_0 !== 3'd1) begin n_fail++;
      $display("FAIL rd_grant: got ready=%b rsp_valid=%b id=%0d expected 010/1/1", ready0, rv_0, rid_0); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (rv_0 !== 1'b1 || rid_0 !== 3'd1 || rr1_0 !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL rd_data: got valid=%b id=%0d rd1=%h expected 1/1/deadbeef", rv_0, rid_0, rr1_0); end
    n_cmp++; if (ready0 !== '0 || we_0 !== 1'b0) begin n_fail++;
      $display("FAIL no_req: got ready=%b we=%b expected 000/0", ready0, we_0); end
    $display("write_read: rsp_id=%0d rd1=%h", rid_0, rr1_0);
    tick();
    @(negedge clk);
    n_cmp++; if (rv_0 !== 1'b0) begin n_fail++; $display("FAIL no_req_rsp: got %b expected 0", rv_0); end
    tick();
  endtask

  task automatic test_alternate();
    logic [N-1:0] exp_r;
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_r = (k % 2 == 0) ? 3'b001 : 3'b010;
      n_cmp++; if (ready0 !== exp_r) begin n_fail++;
        $display("FAIL alt_grant[%0d]: got %b expected %b", k, ready0, exp_r); end
      if (k > 0) begin
        n_cmp++; if (rv_0 !== 1'b1 || rid_0 !== IDW'((k - 1) % 2)) begin n_fail++;
          $display("FAIL alt_rsp[%0d]: got valid=%b id=%0d expected 1/%0d", k, rv_0, rid_0, (k - 1) % 2); end
      end
      $display("alternate %0d: ready=%b rsp_id=%0d", k, ready0, rid_0);
      tick();
    end
    idle();
  endtask

  task automatic test_lock();
    logic [N-1:0] exp_r;
    int wait_cnt, max_wait;
    do_reset();
    wait_cnt = 0; max_wait = 0;
    set_req(0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 5'd0, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 5'd2, 5'd2, 5'd0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_r = (k % 4 == 3) ? 3'b010 : 3'b001;
      n_cmp++; if (ready0 !== exp_r) begin n_fail++;
        $display("FAIL lock_grant[%0d]: got %b expected %b", k, ready0, exp_r); end
      if (ready0[1]) wait_cnt = 0; else wait_cnt++;
      if (wait_cnt > max_wait) max_wait = wait_cnt;
      $display("lock %0d: ready=%b", k, ready0);
      tick();
    end
    n_cmp++; if (max_wait > LMAX) begin n_fail++;
      $display("FAIL lock_starve: got wait %0d expected <= %0d", max_wait, LMAX); end
    idle();
  endtask

  task automatic test_zero_protect();
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234);
    @(negedge clk);
    n_cmp++; if (ready0 !== 3'b001 || ready1 !== 3'b001) begin n_fail++;
      $display("FAIL zp_grant: got %b/%b expected 001/001", ready0, ready1); end
    n_cmp++; if (we_0 !== 1'b0) begin n_fail++; $display("FAIL zp_we3: got %b expected 0", we_0); end
    n_cmp++; if (we_1 !== 1'b1) begin n_fail++; $display("FAIL nz_we3: got %b expected 1", we_1); end
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    n_cmp++; if (rv_0 !== 1'b1 || zd_0 !== 1'b1 || rr1_0 !== 32'h0) begin n_fail++;
      $display("FAIL zp_flag: got valid=%b zd=%b rd1=%h expected 1/1/0", rv_0, zd_0, rr1_0); end
    n_cmp++; if (rv_1 !== 1'b1 || rid_1 !== 3'd0 || zd_1 !== 1'b0) begin n_fail++;
      $display("FAIL nz_flag: got valid=%b id=%0d zd=%b expected 1/0/0", rv_1, rid_1, zd_1); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (rr1_0 !== 32'h0 || zd_0 !== 1'b0) begin n_fail++;
      $display("FAIL zp_r0: got rd1=%h zd=%b expected 0/0", rr1_0, zd_0); end
    n_cmp++; if (rr1_1 !== 32'h1234 || rr2_1 !== 32'h1234) begin n_fail++;
      $display("FAIL nz_r0: got rd1=%h rd2=%h expected 1234/1234", rr1_1, rr2_1); end
    $display("zero_protect: zp r0=%h nz r0=%h", rr1_0, rr1_1);
    tick();
  endtask

  task automatic test_rbw();
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h11);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 32'h55);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0);
    @(negedge clk);
    n_cmp++; if (rr1_0 !== 32'h11) begin n_fail++; $display("FAIL rbw_old: got %h expected 11", rr1_0); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (rr1_0 !== 32'h55 || rr2_0 !== 32'h55) begin n_fail++;
      $display("FAIL rbw_new: got %h/%h expected 55/55", rr1_0, rr2_0); end
    $display("read_before_write: new r7=%h", rr1_0);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd1, 5'd0, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 5'd2, 5'd2, 5'd0, 32'h0);
    @(negedge clk);
    n_cmp++; if (ready0 !== 3'b001) begin n_fail++; $display("FAIL mid_pre: got %b expected 001", ready0); end
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rv_0 !== 1'b0 || ready0 !== '0) begin n_fail++;
      $display("FAIL mid_rst: got valid=%b ready=%b expected 0/000", rv_0, ready0); end
    tick();
    @(negedge clk);
    n_cmp++; if (rv_0 !== 1'b0) begin n_fail++; $display("FAIL mid_hold: got %b expected 0", rv_0); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (ready0 !== 3'b001) begin n_fail++; $display("FAIL mid_first: got %b expected 001", ready0); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (rv_0 !== 1'b1 || rid_0 !== 3'd0) begin n_fail++;
      $display("FAIL mid_rsp: got valid=%b id=%0d expected 1/0", rv_0, rid_0); end
    $display("reset_mid: first grant id=%0d", rid_0);
    tick();
  endtask

  task automatic test_random();
    logic [31:0]  sh [32];
    logic [N-1:0] exp_r;
    logic [4:0]   ga1, ga2, ga3;
    logic [31:0]  gwd, p_rd1, p_rd2;
    logic         gwe, p_valid, p_zd;
    int           m_ptr, m_owner, m_cnt, g, c, p_id;
    rst_n = 1'b0; rf_clear = 1'b1; idle();
    tick(); tick();
    rf_clear = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 32; i++) sh[i] = '0;
    m_ptr = 0; m_owner = -1; m_cnt = 0; p_valid = 1'b0; p_zd = 1'b0; p_id = 0;
    p_rd1 = '0; p_rd2 = '0;
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
      g = -1;
      if (m_owner >= 0 && req_valid[m_owner]) g = m_owner;
      else for (int k = 0; k < N; k++) if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_r = '0; ga1 = '0; ga2 = '0; ga3 = '0; gwd = '0; gwe = 1'b0;
      if (g >= 0) begin
        exp_r[g] = 1'b1;
        ga1 = req_a1[5*g +: 5]; ga2 = req_a2[5*g +: 5]; ga3 = req_a3[5*g +: 5];
        gwd = req_wd[32*g +: 32]; gwe = req_we[g];
      end
      @(negedge clk);
      n_cmp++; if (ready0 !== exp_r) begin n_fail++;
        $display("FAIL rnd_grant[%0d]: got %b expected %b", t, ready0, exp_r); end
      n_cmp++; if ({a1_0, a2_0, a3_0, wd_0} !== {ga1, ga2, ga3, gwd} || we_0 !== (gwe && ga3 != 0)) begin n_fail++;
        $display("FAIL rnd_bus[%0d]: got %0d/%0d/%0d/%h we=%b expected %0d/%0d/%0d/%h we=%b",
                 t, a1_0, a2_0, a3_0, wd_0, we_0, ga1, ga2, ga3, gwd, gwe && ga3 != 0); end
      n_cmp++; if (rv_0 !== p_valid || zd_0 !== p_zd) begin n_fail++;
        $display("FAIL rnd_rspv[%0d]: got valid=%b zd=%b expected %b/%b", t, rv_0, zd_0, p_valid, p_zd); end
      if (p_valid) begin
        n_cmp++; if (rid_0 !== IDW'(p_id) || rr1_0 !== p_rd1 || rr2_0 !== p_rd2) begin n_fail++;
          $display("FAIL rnd_rsp[%0d]: got id=%0d %h/%h expected %0d %h/%h", t, rid_0, rr1_0, rr2_0, p_id, p_rd1, p_rd2); end
      end
      $display("random %0d: valid=%b lock=%b grant=%0d", t, req_valid, req_lock, g);
      p_valid = (g >= 0); p_id = g; p_rd1 = sh[ga1]; p_rd2 = sh[ga2];
      p_zd = (g >= 0) && gwe && (ga3 == 0);
      if (g >= 0 && gwe && ga3 != 0) sh[ga3] = gwd;
      if (g >= 0 && req_lock[g]) begin
        c = ((m_owner == g) ? m_cnt : 0) + 1;
        if (c >= LMAX) begin m_owner = -1; m_cnt = 0; m_ptr = (g + 1) % N; end
        else begin m_owner = g; m_cnt = c; end
      end else begin
        m_owner = -1; m_cnt = 0;
        if (g >= 0) m_ptr = (g + 1) % N;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_lock();
    test_zero_protect();
    test_rbw();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "bench did not complete in time");
  end

endmodule
